// File: rtl/adder_pkg.sv
// Shared definitions for the segmented adder family (pipelined_adder and later ALU blocks).
//   stages()             number of SEG-bit segments in a WIDTH-bit word
//   stage_rec_t          per-stage control record {valid, carry, sub}
//   `ADDER_WIDTH_CHECK   elaboration guard: WIDTH must be a positive multiple of SEG
// No ports; import with `import adder_pkg::*;`.

`ifndef ADDER_WIDTH_CHECK
`define ADDER_WIDTH_CHECK(W, S) \
  if ((S) == 0 || (S) > (W) || ((W) % (S)) != 0) begin : g_width_check \
    $error("adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", (W), (S)); \
  end
`endif

package adder_pkg;

  // Falls back to 1 on illegal combinations so that array sizing stays sane long enough for
  // the width check to report the real problem.
  function automatic int unsigned stages(input int unsigned width, input int unsigned seg);
    if (seg == 0 || seg > width) begin
      return 1;
    end
    return width / seg;
  endfunction

  typedef struct packed {
    logic valid;  // stage holds a live operation
    logic carry;  // carry out of this stage's segment
    logic sub;    // operation is a subtract (B inverted, carry-in forced)
  } stage_rec_t;

endpackage

// File: rtl/adder_segment.sv
// One SEG-bit slice of the pipelined adder.
// Adds a + b + cin; the segment sum is registered on load, the carry-out is combinational so
// the enclosing pipeline can register it alongside the stage's control record.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture the new segment sum
//   a, b, cin    segment operands (b already inverted for subtract) and carry-in
//   sum          registered segment sum
//   cout         combinational carry-out of this segment

module adder_segment
  import adder_pkg::*;
#(
  parameter int unsigned SEG = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0]   total;
  logic [SEG-1:0] sum_q;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  assign cout  = total[SEG];
  assign sum   = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (load) begin
      sum_q <= total[SEG-1:0];
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Elastic pipelined adder: WIDTH-bit A + B + Cin computed SEG bits per stage, carry registered
// between stages, one operation per cycle, latency STAGES cycles.
// Optional feature macro: PIPELINED_ADDER_SUB_EN adds a Sub input (Sum = A - B, Cin ignored).
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (A, B, Cin[, Sub])
//   out_valid / out_ready result handshake (Sum, Cout, Ovf)
//   Sum                   A + B' + Cin' modulo 2^WIDTH
//   Cout                  carry out of the MSB (1 = no borrow when subtracting)
//   Ovf                   signed overflow of the effective addition
// Stage k owns segment k. Each stage register carries the full operand words forward (upper
// segments still to be added) and the finished lower sum segments; synthesis trims the dead
// bits. Data registers only move when a live operation enters a stage, so an empty output
// keeps showing the last result.

module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned STAGES = stages(WIDTH, SEG);

  `ADDER_WIDTH_CHECK(WIDTH, SEG)

  logic sub_in0;
`ifdef PIPELINED_ADDER_SUB_EN
  assign sub_in0 = Sub;
`else
  assign sub_in0 = 1'b0;
`endif

  // Stage state
  stage_rec_t       ctrl_q [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] lo_q   [STAGES];  // finished segments below this stage's own segment
  logic             amsb_q;           // sign of A as seen by the last stage
  logic             bmsb_q;           // sign of effective B as seen by the last stage

  // Per-stage inputs and views
  logic [WIDTH-1:0] a_in     [STAGES];
  logic [WIDTH-1:0] b_in     [STAGES];
  logic [WIDTH-1:0] sum_word [STAGES];
  logic [SEG-1:0]   seg_a    [STAGES];
  logic [SEG-1:0]   seg_b    [STAGES];
  logic [SEG-1:0]   seg_sum  [STAGES];
  logic             c_in     [STAGES];
  logic             c_out    [STAGES];
  logic             s_in     [STAGES];
  logic             v_in     [STAGES];
  logic [STAGES-1:0] load;   // stage may take whatever is upstream (valid or bubble)
  logic [STAGES-1:0] dload;  // stage takes a live operation: data registers move

  always_comb begin
    a_in[0] = A;
    b_in[0] = B;
    s_in[0] = sub_in0;
    c_in[0] = sub_in0 | Cin;  // subtract forces carry-in of the two's complement
    v_in[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = ctrl_q[k-1].sub;
      c_in[k] = ctrl_q[k-1].carry;
      v_in[k] = ctrl_q[k-1].valid;
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      seg_a[k] = a_in[k][k*SEG +: SEG];
      seg_b[k] = b_in[k][k*SEG +: SEG] ^ {SEG{s_in[k]}};
      sum_word[k] = lo_q[k];
      sum_word[k][k*SEG +: SEG] = seg_sum[k];
    end
  end

  // Backward ready chain: a stage frees up when it is empty or its contents move on.
  always_comb begin
    load = '0;
    load[STAGES-1] = !ctrl_q[STAGES-1].valid || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      load[k] = !ctrl_q[k].valid || load[k+1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      dload[k] = load[k] && v_in[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(
      .SEG(SEG)
    ) u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .load (dload[k]),
      .a    (seg_a[k]),
      .b    (seg_b[k]),
      .cin  (c_in[k]),
      .sum  (seg_sum[k]),
      .cout (c_out[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        ctrl_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        lo_q[k]   <= '0;
      end
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          ctrl_q[k].valid <= v_in[k];
        end
        if (dload[k]) begin
          ctrl_q[k].carry <= c_out[k];
          ctrl_q[k].sub   <= s_in[k];
          a_q[k]          <= a_in[k];
          b_q[k]          <= b_in[k];
        end
      end
      // Stage 0 has no finished segments below it; lo_q[0] stays zero.
      for (int k = 1; k < int'(STAGES); k++) begin
        if (dload[k]) begin
          lo_q[k] <= sum_word[k-1];
        end
      end
      if (dload[STAGES-1]) begin
        amsb_q <= a_in[STAGES-1][WIDTH-1];
        bmsb_q <= b_in[STAGES-1][WIDTH-1] ^ s_in[STAGES-1];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = ctrl_q[STAGES-1].valid;
  assign Sum       = sum_word[STAGES-1];
  assign Cout      = ctrl_q[STAGES-1].carry;
  assign Ovf       = (amsb_q == bmsb_q) && (Sum[WIDTH-1] != amsb_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, SEG=8, four stages).
// A queue-based reference model predicts every result from plain 33-bit arithmetic; a single
// negedge process compares each output transfer against it. Directed tests pin the model with
// hand-computed literals, latency, backpressure, full-rate flow and asynchronous reset.

module tb_pipelined_adder;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SEG    = 8;
  localparam int unsigned STAGES = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  A         = '0;
  logic [WIDTH-1:0]  B         = '0;
  logic              Cin       = 1'b0;
  logic              sub       = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  Sum;
  logic              Cout;
  logic              Ovf;

  always #5 clk = ~clk;

  pipelined_adder #(
    .WIDTH(WIDTH),
    .SEG  (SEG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .Sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (Sum),
    .Cout     (Cout),
    .Ovf      (Ovf)
  );

  int          checks    = 0;
  int          errors    = 0;
  int          out_count = 0;
  logic [33:0] exp_q[$];  // {ovf, cout, sum}
  logic [33:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic s);
    logic [31:0] be;
    logic        ce;
    logic [32:0] t;
    be = s ? ~b : b;
    ce = s ? 1'b1 : cin;
    t  = {1'b0, a} + {1'b0, be} + {32'd0, ce};
    return {(a[31] == be[31]) && (t[31] != a[31]), t};
  endfunction

  // Compare process: pop on every output transfer, push on every input transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          chk("result_without_input", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("model_sum", 64'(Sum), 64'(mon_e[31:0]));
          chk("model_cout", 64'(Cout), 64'(mon_e[32]));
          chk("model_ovf", 64'(Ovf), 64'(mon_e[33]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Cin, sub));
      end
    end
  end

  // Anything in flight at reset is discarded by the DUT and must never be expected.
  always @(negedge rst_n) exp_q.delete();

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Single op into an empty pipe; checks latency and hand-computed result.
  task automatic op_wait(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic s, input logic [31:0] e_sum,
                         input logic e_cout, input logic e_ovf);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = a; B = b; Cin = cin; sub = s;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(STAGES));
    chk({name, "_sum"}, 64'(Sum), 64'(e_sum));
    chk({name, "_cout"}, 64'(Cout), 64'(e_cout));
    chk({name, "_ovf"}, 64'(Ovf), 64'(e_ovf));
  endtask

  initial begin
    int   c;
    int   sent;
    int   base;
    logic fired;
    logic need_new;

    // 1. Reset held with in_valid asserted.
    rst_n = 1'b0; in_valid = 1'b1; A = 32'h1234_5678; B = 32'h1; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(Sum), 64'd0);
    chk("rst_cout", 64'(Cout), 64'd0);
    chk("rst_ovf", 64'(Ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end

    // 2. Carry ripple across three segments, latency.
    op_wait("ripple", 32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

    // 3. Wrap and signed overflow.
    op_wait("wrap", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    op_wait("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    op_wait("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    repeat (3) tick();
    chk("empty_out_valid", 64'(out_valid), 64'd0);
    chk("empty_sum_hold", 64'(Sum), 64'h8000_0000);
    chk("empty_ovf_hold", 64'(Ovf), 64'd1);

    // 4. Backpressure: 10 ops, consumer stalled for 6 cycles.
    out_ready = 1'b0;
    base = out_count; sent = 0; c = 0; need_new = 1'b1;
    while (sent < 10 && c < 200) begin
      if (c == 6) out_ready = 1'b1;
      if (need_new) begin
        A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b1;
      @(negedge clk);
      fired = in_ready;
      if (c < 4) chk("bp_in_ready_filling", 64'(in_ready), 64'd1);
      else if (c < 6) chk("bp_in_ready_full", 64'(in_ready), 64'd0);
      if (c == 5) chk("bp_out_valid_full", 64'(out_valid), 64'd1);
      tick();
      if (fired) sent++;
      need_new = fired;
      c++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(sent), 64'd10);
    drain("bp_drain");
    chk("bp_result_count", 64'(out_count - base), 64'd10);

    // 5. Full-rate overlap.
    out_ready = 1'b1;
    base = out_count;
    for (int i = 0; i < 100; i++) begin
      A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge clk);
      chk("rate_in_ready", 64'(in_ready), 64'd1);
      if (i >= int'(STAGES)) chk("rate_out_valid", 64'(out_valid), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    drain("rate_drain");
    chk("rate_result_count", 64'(out_count - base), 64'd100);

    // 6. Asynchronous reset with three ops in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 32'h1000 + i; B = 32'h1; Cin = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    chk("mid_out_valid_before_rst", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(Sum), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    #13 rst_n = 1'b1;
    out_ready = 1'b1;
    base = out_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_no_ghost", 64'(out_valid), 64'd0);
    end
    chk("mid_ghost_count", 64'(out_count - base), 64'd0);
    op_wait("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

`ifdef PIPELINED_ADDER_SUB_EN
    op_wait("sub", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`endif

    tick();
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
